// File: rtl/floating_point_accumulator.sv
// Packet-based floating-point accumulator.
// Sums a stream of {sign, exponent, mantissa} operands into one result per
// packet (delimited by in_last) and holds it until the consumer takes it.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_data/in_subtract/in_last      operand, negate flag, packet end marker
//   in_valid/in_ready                input handshake
//   out_data                         packet sum
//   out_*_flag                       sticky adder exceptions over the packet
//   out_count                        accepted operands, saturating at 16'hFFFF
//   out_valid/out_ready              output handshake

// Combinational adder: a + (subtract ? -b : b).
// Subnormal operands are treated as zero; results below the normal range
// flush to a signed zero with underflow_flag set. Any NaN operand yields the
// canonical NaN {1, all-ones exponent, quiet bit}.
module floating_point_adder #(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter int unsigned ROUND_TO_NEAREST = 1,
    parameter int unsigned ROUNDING_BITS    = 3
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
    input  logic                                   subtract,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
    output logic                                   underflow_flag,
    output logic                                   overflow_flag,
    output logic                                   invalid_operation_flag
);
    localparam int unsigned E   = EXPONENT_WIDTH;
    localparam int unsigned M   = MANTISSA_WIDTH;
    localparam int unsigned R   = ROUNDING_BITS;
    localparam int unsigned W   = E + M + 1;
    localparam int unsigned SW  = M + 1 + R;
    localparam int unsigned NW  = SW + 1;
    localparam int unsigned LZW = $clog2(NW) + 1;
    localparam int unsigned XW  = E + LZW + 2;
    localparam logic [W-1:0] QNAN = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** E) - 1);

    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] ma, mb;
    logic         nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sa     = a[W-1];
    assign ea     = a[W-2:M];
    assign ma     = a[M-1:0];
    assign sb     = b[W-1] ^ subtract;
    assign eb     = b[W-2:M];
    assign mb     = b[M-1:0];
    assign nan_a  = (&ea) && (|ma);
    assign nan_b  = (&eb) && (|mb);
    assign inf_a  = (&ea) && !(|ma);
    assign inf_b  = (&eb) && !(|mb);
    assign zero_a = !(|ea);
    assign zero_b = !(|eb);

    logic                 sx, sy, zx, zy, sticky, found, inc;
    logic [E-1:0]         ex, ey, diff;
    logic [M-1:0]         mx, my;
    logic [SW-1:0]        sig_x, sig_y, sig_y_sh;
    logic [NW-1:0]        sum, norm;
    logic [LZW-1:0]       lz;
    logic signed [XW-1:0] exp_n;
    logic [M+1:0]         rounded;

    // Align, add, normalise and round the finite path.
    always_comb begin
        sx = sa; ex = ea; mx = ma; zx = zero_a;
        sy = sb; ey = eb; my = mb; zy = zero_b;
        // Larger magnitude goes to x so only y is ever shifted and x - y >= 0.
        if ({eb, mb} > {ea, ma}) begin
            sx = sb; ex = eb; mx = mb; zx = zero_b;
            sy = sa; ey = ea; my = ma; zy = zero_a;
        end
        sig_x = zx ? '0 : {1'b1, mx, {R{1'b0}}};
        sig_y = zy ? '0 : {1'b1, my, {R{1'b0}}};
        diff  = ex - ey;
        if (32'(diff) >= 32'(SW)) begin
            sig_y_sh = '0;
            sticky   = |sig_y;
        end else begin
            sig_y_sh = sig_y >> diff;
            sticky   = |(sig_y & ~({SW{1'b1}} << diff));
        end
        sig_y_sh[0] = sig_y_sh[0] | sticky;

        if (sx == sy) sum = {1'b0, sig_x} + {1'b0, sig_y_sh};
        else          sum = {1'b0, sig_x} - {1'b0, sig_y_sh};

        exp_n = $signed({{(XW-E){1'b0}}, ex});
        lz    = '0;
        found = 1'b0;
        if (sum[NW-1]) begin
            norm    = {1'b0, sum[NW-1:1]};
            norm[0] = norm[0] | sum[0];
            exp_n   = exp_n + XW'(1);
        end else begin
            for (int i = NW - 2; i >= 0; i--) begin
                if (!found && sum[i]) begin
                    found = 1'b1;
                    lz    = LZW'(NW - 2 - i);
                end
            end
            norm  = sum << lz;
            exp_n = exp_n - $signed({{(XW-LZW){1'b0}}, lz});
        end

        // Round half to even on guard bit, remaining bits act as sticky.
        inc     = (ROUND_TO_NEAREST != 0) && norm[R-1] && ((|norm[R-2:0]) || norm[R]);
        rounded = {1'b0, norm[M+R:R]} + (M+2)'(inc);
        if (rounded[M+1]) begin
            rounded = rounded >> 1;
            exp_n   = exp_n + XW'(1);
        end
    end

    // Special-value selection and exception flags.
    always_comb begin
        result                 = '0;
        underflow_flag         = 1'b0;
        overflow_flag          = 1'b0;
        invalid_operation_flag = 1'b0;
        if (nan_a || nan_b) begin
            result = QNAN;
        end else if (inf_a && inf_b && (sa != sb)) begin
            result                 = QNAN;
            invalid_operation_flag = 1'b1;
        end else if (inf_a) begin
            result = {sa, a[W-2:0]};
        end else if (inf_b) begin
            result = {sb, b[W-2:0]};
        end else if (sum == '0) begin
            result = {sa & sb, {(W-1){1'b0}}};
        end else if (exp_n >= EXP_MAX) begin
            overflow_flag = 1'b1;
            if (ROUND_TO_NEAREST != 0) result = {sx, {E{1'b1}}, {M{1'b0}}};
            else                       result = {sx, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
        end else if (exp_n[XW-1] || (exp_n == '0)) begin
            underflow_flag = 1'b1;
            result         = {sx, {(W-1){1'b0}}};
        end else begin
            result = {sx, exp_n[E-1:0], rounded[M-1:0]};
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, norm[NW-1], rounded[M]};
endmodule

module floating_point_accumulator #(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter int unsigned ROUND_TO_NEAREST = 1,
    parameter int unsigned ROUNDING_BITS    = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data,
    input  logic                                   in_subtract,
    input  logic                                   in_last,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data,
    output logic                                   out_underflow_flag,
    output logic                                   out_overflow_flag,
    output logic                                   out_invalid_operation_flag,
    output logic [15:0]                            out_count,
    output logic                                   out_valid,
    input  logic                                   out_ready
);
    localparam int unsigned W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q;
    logic           uf_q, of_q, inv_q;
    logic [15:0]    count_q;
    logic           accept;
    logic [W-1:0]   add_result;
    logic           add_uf, add_of, add_inv;

    floating_point_adder #(
        .EXPONENT_WIDTH  (EXPONENT_WIDTH),
        .MANTISSA_WIDTH  (MANTISSA_WIDTH),
        .ROUND_TO_NEAREST(ROUND_TO_NEAREST),
        .ROUNDING_BITS   (ROUNDING_BITS)
    ) u_adder (
        .a                     (acc_q),
        .b                     (in_data),
        .subtract              (in_subtract),
        .result                (add_result),
        .underflow_flag        (add_uf),
        .overflow_flag         (add_of),
        .invalid_operation_flag(add_inv)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (accept) state_d = in_last ? HOLD : ACCUM;
            HOLD:        if (out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        accept    = in_valid && (state_q != HOLD);
    end

    // Datapath: first beat loads raw (sign-adjusted), later beats go through the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            uf_q    <= 1'b0;
            of_q    <= 1'b0;
            inv_q   <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                acc_q   <= {in_data[W-1] ^ in_subtract, in_data[W-2:0]};
                uf_q    <= 1'b0;
                of_q    <= 1'b0;
                inv_q   <= 1'b0;
                count_q <= 16'd1;
            end else begin
                acc_q   <= add_result;
                uf_q    <= uf_q | add_uf;
                of_q    <= of_q | add_of;
                inv_q   <= inv_q | add_inv;
                count_q <= (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end
        end
    end

    assign out_data                   = acc_q;
    assign out_underflow_flag         = uf_q;
    assign out_overflow_flag          = of_q;
    assign out_invalid_operation_flag = inv_q;
    assign out_count                  = count_q;
endmodule

// File: tb/tb_floating_point_accumulator.sv
// Directed bench for floating_point_accumulator at FP32 defaults.
// Ports driven: clk, rst, in_* stream, out_ready; all outputs observed.
module tb_floating_point_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_subtract, in_last, in_valid, in_ready;
    logic [31:0] out_data;
    logic        out_underflow_flag, out_overflow_flag, out_invalid_operation_flag;
    logic [15:0] out_count;
    logic        out_valid, out_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    floating_point_accumulator dut (
        .clk                       (clk),
        .rst                       (rst),
        .in_data                   (in_data),
        .in_subtract               (in_subtract),
        .in_last                   (in_last),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .out_data                  (out_data),
        .out_underflow_flag        (out_underflow_flag),
        .out_overflow_flag         (out_overflow_flag),
        .out_invalid_operation_flag(out_invalid_operation_flag),
        .out_count                 (out_count),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready)
    );

    always #5 clk = ~clk;

    // Present one beat and hold it until it is accepted; returns at edge+1.
    task automatic drive_beat(input logic [31:0] d, input logic sub, input logic last,
                              output bit timeout);
        int n;
        timeout     = 1'b0;
        in_data     = d;
        in_subtract = sub;
        in_last     = last;
        in_valid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_subtract = 1'b0;
    endtask

    // Complete the output handshake.
    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_subtract = 1'b0;
        in_data = 32'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_compared++; if (out_data !== 32'h0) begin n_mismatched++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_compared++; if (out_count !== 16'd0) begin n_mismatched++; $display("FAIL reset_count: got %0d want 0", out_count); end
        n_compared++; if ({out_underflow_flag, out_overflow_flag, out_invalid_operation_flag} !== 3'b000) begin
            n_mismatched++; $display("FAIL reset_flags: got %b want 000", {out_underflow_flag, out_overflow_flag, out_invalid_operation_flag}); end
    endtask

    task automatic test_add();
        bit t0, t1;
        drive_beat(32'h3F800000, 1'b0, 1'b0, t0);
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL add_mid_valid: got %b want 0", out_valid); end
        drive_beat(32'h40000000, 1'b0, 1'b1, t1);
        n_compared++; if ({t0, t1} !== 2'b00) begin n_mismatched++; $display("FAIL add_timeout: got %b want 00", {t0, t1}); end
        n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("FAIL add_valid_latency: got %b want 1", out_valid); end
        n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL add_hold_ready: got %b want 0", in_ready); end
        n_compared++; if (out_data !== 32'h40400000) begin n_mismatched++; $display("FAIL add_data: got %h want 40400000", out_data); end
        n_compared++; if (out_count !== 16'd2) begin n_mismatched++; $display("FAIL add_count: got %0d want 2", out_count); end
        n_compared++; if ({out_underflow_flag, out_overflow_flag, out_invalid_operation_flag} !== 3'b000) begin
            n_mismatched++; $display("FAIL add_flags: got %b want 000", {out_underflow_flag, out_overflow_flag, out_invalid_operation_flag}); end
        release_result();
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL add_release_valid: got %b want 0", out_valid); end
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL add_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_subtract();
        bit t0, t1, t2;
        drive_beat(32'h40400000, 1'b0, 1'b0, t0);
        drive_beat(32'h3F800000, 1'b1, 1'b1, t1);
        n_compared++; if (out_data !== 32'h40000000) begin n_mismatched++; $display("FAIL sub_data: got %h want 40000000", out_data); end
        release_result();
        drive_beat(32'h3F800000, 1'b1, 1'b1, t2);
        n_compared++; if ({t0, t1, t2} !== 3'b000) begin n_mismatched++; $display("FAIL sub_timeout: got %b want 000", {t0, t1, t2}); end
        n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_compared++; if (out_data !== 32'hBF800000) begin n_mismatched++; $display("FAIL single_neg_data: got %h want bf800000", out_data); end
        n_compared++; if (out_count !== 16'd1) begin n_mismatched++; $display("FAIL single_count: got %0d want 1", out_count); end
        release_result();
    endtask

    task automatic test_invalid();
        bit t0, t1;
        drive_beat(32'h7F800000, 1'b0, 1'b0, t0);
        drive_beat(32'hFF800000, 1'b0, 1'b1, t1);
        n_compared++; if (out_data !== 32'hFFC00000) begin n_mismatched++; $display("FAIL inf_minus_inf_data: got %h want ffc00000", out_data); end
        n_compared++; if (out_invalid_operation_flag !== 1'b1) begin n_mismatched++; $display("FAIL invalid_flag: got %b want 1", out_invalid_operation_flag); end
        release_result();
        // A NaN in the accumulator survives further beats; a quiet NaN is not invalid.
        drive_beat(32'h7FC00000, 1'b0, 1'b0, t0);
        drive_beat(32'h3F800000, 1'b0, 1'b1, t1);
        n_compared++; if (out_data !== 32'hFFC00000) begin n_mismatched++; $display("FAIL nan_prop_data: got %h want ffc00000", out_data); end
        n_compared++; if (out_invalid_operation_flag !== 1'b0) begin n_mismatched++; $display("FAIL nan_prop_invalid: got %b want 0", out_invalid_operation_flag); end
        release_result();
    endtask

    task automatic test_overflow_underflow();
        bit t0, t1;
        drive_beat(32'h7F7FFFFF, 1'b0, 1'b0, t0);
        drive_beat(32'h7F7FFFFF, 1'b0, 1'b1, t1);
        n_compared++; if (out_data !== 32'h7F800000) begin n_mismatched++; $display("FAIL ovf_data: got %h want 7f800000", out_data); end
        n_compared++; if (out_overflow_flag !== 1'b1) begin n_mismatched++; $display("FAIL ovf_flag: got %b want 1", out_overflow_flag); end
        release_result();
        // 2^-126 - 1.5*2^-126 = -0.5*2^-126 falls below the normal range.
        drive_beat(32'h00800000, 1'b0, 1'b0, t0);
        drive_beat(32'h00C00000, 1'b1, 1'b1, t1);
        n_compared++; if (out_data !== 32'h80000000) begin n_mismatched++; $display("FAIL unf_data: got %h want 80000000", out_data); end
        n_compared++; if ({out_underflow_flag, out_overflow_flag} !== 2'b10) begin
            n_mismatched++; $display("FAIL unf_flags: got %b want 10", {out_underflow_flag, out_overflow_flag}); end
        release_result();
    endtask

    task automatic test_back_to_back();
        bit t0, t1, t2;
        drive_beat(32'h3F800000, 1'b0, 1'b0, t0);
        drive_beat(32'h3F800000, 1'b0, 1'b0, t1);
        drive_beat(32'h3F800000, 1'b0, 1'b1, t2);
        n_compared++; if (out_data !== 32'h40400000) begin n_mismatched++; $display("FAIL b2b_data: got %h want 40400000", out_data); end
        n_compared++; if (out_count !== 16'd3) begin n_mismatched++; $display("FAIL b2b_count: got %0d want 3", out_count); end
        release_result();
    endtask

    task automatic test_backpressure();
        bit t0;
        drive_beat(32'h40000000, 1'b0, 1'b1, t0);
        in_data = 32'h3F800000; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            n_compared++; if ({out_valid, out_data, out_count} !== {1'b1, 32'h40000000, 16'd1}) begin
                n_mismatched++; $display("FAIL bp_stable[%0d]: got %b %h %0d want 1 40000000 1", i, out_valid, out_data, out_count); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_compared++; if ({out_valid, in_ready} !== 2'b01) begin
            n_mismatched++; $display("FAIL bp_handshake: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_compared++; if ({out_valid, out_data, out_count} !== {1'b1, 32'h3F800000, 16'd1}) begin
            n_mismatched++; $display("FAIL bp_new_packet: got %b %h %0d want 1 3f800000 1", out_valid, out_data, out_count); end
        release_result();
    endtask

    task automatic test_reset_midpacket();
        bit t0, t1, t2;
        drive_beat(32'h40000000, 1'b0, 1'b0, t0);
        drive_beat(32'h40000000, 1'b0, 1'b0, t1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_compared++; if ({out_valid, out_count} !== {1'b0, 16'd0}) begin
            n_mismatched++; $display("FAIL rst_mid_state: got valid=%b count=%0d want 0 0", out_valid, out_count); end
        repeat (3) @(posedge clk);
        #1;
        n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL rst_mid_no_output: got %b want 0", out_valid); end
        drive_beat(32'h3F800000, 1'b0, 1'b1, t2);
        n_compared++; if ({t0, t1, t2} !== 3'b000) begin n_mismatched++; $display("FAIL rst_mid_timeout: got %b want 000", {t0, t1, t2}); end
        n_compared++; if ({out_valid, out_data, out_count} !== {1'b1, 32'h3F800000, 16'd1}) begin
            n_mismatched++; $display("FAIL rst_mid_next: got %b %h %0d want 1 3f800000 1", out_valid, out_data, out_count); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_invalid();
        test_overflow_underflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midpacket();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
